// File: rtl/packet_snaplen_trunc.sv
// Capture-path snap-length truncator: forwards each packet through a one-beat
// output slice, cutting it after snaplen bytes and dropping the remainder.
module packet_snaplen_trunc #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128
) (
  input  logic                      axi_aclk,
  input  logic                      reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  input  logic [15:0]               snaplen,
  output logic [31:0]               trunc_count
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam logic [15:0] BEAT_BYTES = 16'(STRB_W);

  typedef enum logic [1:0] {
    SOP  = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [15:0] snap_q, sent_q;
  logic [15:0] snap_eff, sent_eff, rem;
  logic        cut, fwd, trunc_hit;
  logic [STRB_W-1:0]        cut_mask;
  logic [C_TUSER_WIDTH-1:0] tuser_out;

  // Byte-enable mask with the lowest n lanes set.
  function automatic logic [STRB_W-1:0] lsb_mask(input logic [15:0] n);
    logic [STRB_W-1:0] m;
    for (int i = 0; i < STRB_W; i++) begin
      m[i] = (16'(i) < n);
    end
    return m;
  endfunction

  // Clamp the advertised packet length to the snap length.
  function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] lim);
    return (lim != 16'd0 && len > lim) ? lim : len;
  endfunction

  // The SOP beat must use the live snaplen/zero offset since the latches load on that same edge.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = !m_axis_tvalid || m_axis_tready;
    snap_eff      = (state == SOP) ? snaplen : snap_q;
    sent_eff      = (state == SOP) ? 16'd0 : sent_q;
    rem           = snap_eff - sent_eff;
    cut           = (snap_eff != 16'd0) && (rem <= BEAT_BYTES);
    cut_mask      = lsb_mask(rem);
    fwd           = 1'b0;
    trunc_hit     = 1'b0;
    tuser_out     = s_axis_tuser;
    if (state == SOP) begin
      tuser_out[15:0] = clamp_len(s_axis_tuser[15:0], snap_eff);
    end
    case (state)
      SOP, PASS: begin
        fwd = s_axis_tvalid && s_axis_tready;
        if (fwd) begin
          if (cut) begin
            // A cut that removes no bytes (packet exactly snaplen long) is not a truncation.
            trunc_hit = !s_axis_tlast || (|(s_axis_tstrb & ~cut_mask));
            state_nxt = s_axis_tlast ? SOP : DROP;
          end else begin
            state_nxt = s_axis_tlast ? SOP : PASS;
          end
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = SOP;
        end
      end
      default: state_nxt = SOP;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      state <= SOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Per-packet bookkeeping and the truncation counter.
  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      snap_q      <= 16'd0;
      sent_q      <= 16'd0;
      trunc_count <= 32'd0;
    end else begin
      if (fwd) begin
        if (state == SOP) begin
          snap_q <= snaplen;
        end
        if (cut || s_axis_tlast) begin
          sent_q <= 16'd0;
        end else begin
          sent_q <= sent_eff + BEAT_BYTES;
        end
      end
      if (trunc_hit) begin
        trunc_count <= trunc_count + 32'd1;
      end
    end
  end

  // Output register slice.
  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
    end else if (fwd) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= cut || s_axis_tlast;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tstrb  <= cut ? (s_axis_tstrb & cut_mask) : s_axis_tstrb;
      m_axis_tuser  <= tuser_out;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_snaplen_trunc.sv
// Bench for packet_snaplen_trunc: byte-stream reference model, per-beat scoreboard,
// directed snaplen cases, throttled random traffic and a mid-packet reset.
module tb_packet_snaplen_trunc;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;

  logic          clk;
  logic          reset;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast, m_tready;
  logic [15:0]   snaplen;
  logic [31:0]   trunc_count;

  packet_snaplen_trunc #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW)) dut (
    .axi_aclk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .snaplen(snaplen), .trunc_count(trunc_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t pkt[$];
  beat_t exp_q[$];
  int    cur_nout;
  int    exp_trunc;
  bit    throttle;
  int    errors, checks;
  int    pkt_beats, last_beats;
  logic [SW-1:0] last_tstrb;
  logic [15:0]   first_user16;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic logic [SW-1:0] ones(input int n);
    logic [SW-1:0] m;
    m = '0;
    for (int i = 0; i < SW; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  task automatic make_pkt(input int len);
    beat_t bt;
    int nb;
    pkt.delete();
    nb = (len + SW - 1) / SW;
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < DW / 32; w++) bt.data[w*32 +: 32] = $urandom;
      for (int w = 0; w < UW / 32; w++) bt.user[w*32 +: 32] = $urandom;
      if (b == 0) bt.user[15:0] = 16'(len);
      bt.last = (b == nb - 1);
      bt.strb = bt.last ? ones(len - b * SW) : '1;
      pkt.push_back(bt);
    end
  endtask

  // Reference: keep the first snap bytes of the byte stream, re-beat them, clamp the length field.
  task automatic model_push(input int len, input int snap);
    beat_t bt;
    bit truncate;
    int nout;
    truncate = (snap != 0) && (len > snap);
    nout = truncate ? (snap + SW - 1) / SW : pkt.size();
    for (int b = 0; b < nout; b++) begin
      bt = pkt[b];
      if (b == 0 && snap != 0 && int'(bt.user[15:0]) > snap) bt.user[15:0] = 16'(snap);
      if (truncate && b == nout - 1) begin
        bt.last = 1'b1;
        bt.strb = bt.strb & ones(snap - b * SW);
      end
      exp_q.push_back(bt);
    end
    if (truncate) exp_trunc++;
    cur_nout = nout;
  endtask

  task automatic wait_accept(output bit ok);
    int cyc;
    bit rdy;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 2000) begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      cyc++;
    end
    ok = rdy;
  endtask

  task automatic send_pkt(input int len, input int snap, input int max_beats, input bit gaps);
    bit ok;
    make_pkt(len);
    model_push(len, snap);
    snaplen = 16'(snap);
    for (int b = 0; b < pkt.size() && b < max_beats; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tdata  = pkt[b].data;
      s_tstrb  = pkt[b].strb;
      s_tuser  = pkt[b].user;
      s_tlast  = pkt[b].last;
      s_tvalid = 1'b1;
      wait_accept(ok);
      if (!ok) abort("s_handshake");
      if (b == 0) snaplen = 16'($urandom);
      if (!throttle && b < cur_nout)
        chk("latency1", {63'd0, (m_tvalid === 1'b1) && (m_tdata === pkt[b].data)}, 64'd1);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) abort("drain");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_tdata_nz", {63'd0, |m_tdata}, 64'd0);
    chk("rst_tstrb", 64'(m_tstrb), 64'd0);
    chk("rst_tuser_nz", {63'd0, |m_tuser}, 64'd0);
    chk("rst_trunc_count", 64'(trunc_count), 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_trunc = 0;
  endtask

  // Scoreboard: checks each transferred beat and that a stalled beat never changes.
  initial begin
    beat_t hb, e;
    bit held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
        pkt_beats = 0;
      end else begin
        if (held) begin
          checks++;
          if (!m_tvalid || m_tdata !== hb.data || m_tstrb !== hb.strb ||
              m_tuser !== hb.user || m_tlast !== hb.last) begin
            errors++;
            $display("FAIL stall_hold: tvalid=%0b strb=%h last=%0b, held strb=%h last=%0b",
                     m_tvalid, m_tstrb, m_tlast, hb.strb, hb.last);
          end
        end
        held = m_tvalid && !m_tready;
        hb.data = m_tdata;
        hb.strb = m_tstrb;
        hb.user = m_tuser;
        hb.last = m_tlast;
        if (m_tvalid && m_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: strb=%h last=%0b", m_tstrb, m_tlast);
          end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.data || m_tstrb !== e.strb || m_tuser !== e.user || m_tlast !== e.last) begin
              errors++;
              $display("FAIL beat_compare: got strb=%h last=%0b len=%0d data_ok=%0b, expected strb=%h last=%0b len=%0d",
                       m_tstrb, m_tlast, m_tuser[15:0], m_tdata === e.data, e.strb, e.last, e.user[15:0]);
            end
          end
          if (pkt_beats == 0) first_user16 = m_tuser[15:0];
          pkt_beats++;
          if (m_tlast) begin
            last_beats = pkt_beats;
            last_tstrb = m_tstrb;
            pkt_beats  = 0;
          end
        end
      end
    end
  end

  initial begin
    int snaps[7];
    errors = 0; checks = 0; exp_trunc = 0; throttle = 1'b0;
    pkt_beats = 0; last_beats = 0; last_tstrb = '0; first_user16 = '0;
    reset = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tstrb = '0; s_tuser = '0; snaplen = '0;
    #1;
    do_reset();

    send_pkt(100, 0, 99, 1'b0);
    drain();
    chk("nosnap_beats", 64'(last_beats), 64'd4);
    chk("nosnap_len", 64'(first_user16), 64'd100);
    chk("nosnap_tstrb", 64'(last_tstrb), 64'h0000000F);
    chk("nosnap_count", 64'(trunc_count), 64'd0);

    send_pkt(100, 64, 99, 1'b0);
    drain();
    chk("snap64_beats", 64'(last_beats), 64'd2);
    chk("snap64_tstrb", 64'(last_tstrb), 64'hFFFFFFFF);
    chk("snap64_len", 64'(first_user16), 64'd64);
    chk("snap64_count", 64'(trunc_count), 64'd1);

    send_pkt(100, 40, 99, 1'b0);
    drain();
    chk("snap40_beats", 64'(last_beats), 64'd2);
    chk("snap40_tstrb", 64'(last_tstrb), 64'h000000FF);
    chk("snap40_len", 64'(first_user16), 64'd40);
    chk("snap40_count", 64'(trunc_count), 64'd2);

    send_pkt(64, 64, 99, 1'b0);
    drain();
    chk("exact_beats", 64'(last_beats), 64'd2);
    chk("exact_tstrb", 64'(last_tstrb), 64'hFFFFFFFF);
    chk("exact_count", 64'(trunc_count), 64'd2);

    send_pkt(20, 10, 99, 1'b0);
    drain();
    chk("single_beats", 64'(last_beats), 64'd1);
    chk("single_tstrb", 64'(last_tstrb), 64'h000003FF);
    chk("single_len", 64'(first_user16), 64'd10);
    chk("single_count", 64'(trunc_count), 64'd3);

    throttle = 1'b1;
    snaps = '{0, 10, 32, 40, 64, 100, 1};
    for (int p = 0; p < 1000; p++) begin
      int sn;
      sn = snaps[$urandom_range(0, 6)];
      if (sn == 1) sn = $urandom_range(1, 300);
      send_pkt($urandom_range(1, 220), sn, 99, 1'b1);
    end
    drain();
    chk("random_count", 64'(trunc_count), 64'(exp_trunc));
    throttle = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    send_pkt(100, 64, 3, 1'b0);
    drain();
    chk("pre_reset_count", 64'(trunc_count), 64'(exp_trunc));
    do_reset();
    send_pkt(32, 64, 99, 1'b0);
    drain();
    chk("post_reset_beats", 64'(last_beats), 64'd1);
    chk("post_reset_tstrb", 64'(last_tstrb), 64'hFFFFFFFF);
    chk("post_reset_len", 64'(first_user16), 64'd32);
    chk("post_reset_count", 64'(trunc_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/packet_snaplen_trunc.md
PACKET_SNAPLEN_TRUNC -- requirements
Module: packet_snaplen_trunc

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 256, tdata width in bits (multiple of 64).
REQ-002 SHALL have parameter C_TUSER_WIDTH, default 128, tuser width in bits (at least 16).
REQ-003 SHALL have port axi_aclk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1; it is asynchronous and active-high.
REQ-005 SHALL have port s_axis_tdata/tstrb/tuser/tvalid/tlast, input, C_DATA_WIDTH/C_DATA_WIDTH/8/C_TUSER_WIDTH/1/1, the capture-copy stream from the duplication stage's port 1.
REQ-006 SHALL have port s_axis_tready, output, 1, upstream backpressure.
REQ-007 SHALL have port m_axis_tdata/tstrb/tuser/tvalid/tlast, output, same widths as the slave side, the truncated stream toward DMA.
REQ-008 SHALL have port m_axis_tready, input, 1, downstream backpressure.
REQ-009 SHALL have port snaplen, input, 16, the maximum captured bytes per packet; 0 disables truncation.
REQ-010 SHALL have port trunc_count, output, 32, the number of packets truncated since reset.

Function
REQ-011 SHALL register the output through a single slice: a slave beat accepted at edge N SHALL appear on m_axis at N+1 (latency 1).
REQ-012 SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready in states SOP and PASS, and s_axis_tready = 1 in state DROP.
REQ-013 SHALL hold m_axis_* stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-014 SHALL implement an FSM with states SOP (awaiting first beat), PASS (forwarding the packet) and DROP (discarding the remainder).
REQ-015 SHALL latch snaplen into snap_q on the SOP beat; a snaplen change mid-packet SHALL NOT affect the current packet.
REQ-016 SHALL keep a 16-bit byte counter sent_q, cleared at SOP and incremented by C_DATA_WIDTH/8 per forwarded non-final beat.
REQ-017 SHALL, on the SOP beat, output tuser with bits [15:0] = min(s_axis_tuser[15:0], snap_q) when snap_q != 0, with all other tuser bits unchanged.
REQ-018 SHALL define, for an accepted beat in SOP/PASS, rem = snap_q - sent_q; the beat is the cut beat when snap_q != 0 and rem <= C_DATA_WIDTH/8.
REQ-019 SHALL, on the cut beat, output tlast=1 and tstrb = s_axis_tstrb AND a mask with the lowest rem bits set (byte 0 = tdata[7:0]).
REQ-020 SHALL transition on the cut beat to SOP if s_axis_tlast=1, else to DROP, and increment trunc_count by 1.
REQ-021 SHALL, on a non-cut beat with s_axis_tlast=1, forward the beat unchanged and go to SOP; a packet of length exactly snaplen SHALL NOT count as truncated.
REQ-022 SHALL, in DROP, accept beats without producing output, and go to SOP on s_axis_tlast=1.
REQ-023 SHALL cause trunc_count to wrap from 0xFFFFFFFF to 0.
REQ-024 SHALL pass a single-beat packet that is also the cut beat as one beat with the masked tstrb and the tuser rewrite applied.

Reset
REQ-025 SHALL, while reset=1, force state=SOP, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, sent_q=0, snap_q=0 and trunc_count=0, independent of the clock.
REQ-026 SHALL, on reset asserted mid-packet, discard the partial packet; the first beat accepted after release SHALL be treated as SOP.

Verification
REQ-027 SHALL cover: snaplen=0, a 100-byte packet (4 beats, tuser[15:0]=100) -> 4 beats out identical to the input, trunc_count=0.
REQ-028 SHALL cover: snaplen=64, a 100-byte packet -> 2 beats out, beat 2 tlast=1 with tstrb=0xFFFFFFFF, tuser[15:0]=64, beats 3-4 dropped, trunc_count=1.
REQ-029 SHALL cover: snaplen=40, a 100-byte packet -> beat 2 tstrb=0x000000FF, tlast=1, tuser[15:0]=40.
REQ-030 SHALL cover: snaplen=64, a 64-byte packet -> 2 beats unchanged, trunc_count=0; snaplen=10 with a 20-byte single beat -> tstrb=0x000003FF.
REQ-031 SHALL cover: random m_axis_tready throttling (50%) over 1000 mixed packets -> output equal to the reference-model truncation, no beat lost or duplicated, no data change while stalled.
REQ-032 SHALL cover: reset asserted in DROP, then a new 32-byte packet after release -> that packet is output intact and trunc_count=0.
